// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses R/G/B/? ASCII commands from UART_RX, drives LEDs and sequences the response to UART_TX
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_LED_R,
    output logic       o_LED_G,
    output logic       o_LED_B,
    output logic       o_Cmd_Err,
    output logic       o_Drop
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] T_MAX = '1;
    localparam logic [31:0] RESP_OK = {8'h00, 8'h0A, 8'h4B, 8'h4F};
    localparam logic [31:0] RESP_ERR = {8'h00, 8'h0A, 8'h3F, 8'h45};
    typedef enum logic [1:0] {IDLE, GET_ARG, SEND, WAIT_DONE} state_t;
    state_t state, state_n;
    logic [1:0] sel, sel_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0][7:0] resp, resp_n;
    logic [2:0] len, len_n;
    logic [1:0] idx, idx_n;
    logic [2:0] led, led_n;
    logic tx_dv_n, err_n, drop_n;
    logic [7:0] tx_byte_n;
    logic is_letter, is_arg, is_eol;
    assign is_letter = i_RX_Byte == 8'h52 || i_RX_Byte == 8'h47 || i_RX_Byte == 8'h42;
    assign is_arg = i_RX_Byte == 8'h30 || i_RX_Byte == 8'h31;
    assign is_eol = i_RX_Byte == 8'h0D || i_RX_Byte == 8'h0A;
    // led holds {R,G,B} in active-low form; sel indexes it (2=R, 1=G, 0=B)
    always_comb begin
        state_n = state;
        sel_n = sel;
        timer_n = timer;
        resp_n = resp;
        len_n = len;
        idx_n = idx;
        led_n = led;
        tx_dv_n = 1'b0;
        tx_byte_n = o_TX_Byte;
        err_n = 1'b0;
        drop_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_RX_DV) begin
                    idx_n = 2'd0;
                    if (is_letter) begin
                        sel_n = i_RX_Byte == 8'h52 ? 2'd2 : i_RX_Byte == 8'h47 ? 2'd1 : 2'd0;
                        timer_n = '0;
                        state_n = GET_ARG;
                    end else if (i_RX_Byte == 8'h3F) begin
                        resp_n = {8'h0A, led[0] ? 8'h30 : 8'h31, led[1] ? 8'h30 : 8'h31,
                                  led[2] ? 8'h30 : 8'h31};
                        len_n = 3'd4;
                        state_n = SEND;
                    end else if (!is_eol) begin
                        err_n = 1'b1;
                        resp_n = RESP_ERR;
                        len_n = 3'd3;
                        state_n = SEND;
                    end
                end
            end
            GET_ARG: begin
                if (i_RX_DV) begin
                    if (is_arg) led_n[sel] = ~i_RX_Byte[0];
                    err_n = !is_arg;
                    resp_n = is_arg ? RESP_OK : RESP_ERR;
                    len_n = 3'd3;
                    idx_n = 2'd0;
                    state_n = SEND;
                end else if (timer == T_LAST) begin
                    err_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer == T_MAX ? timer : timer + TW'(1);
                end
            end
            SEND: begin
                drop_n = i_RX_DV;
                if (!i_TX_Active) begin
                    tx_dv_n = 1'b1;
                    tx_byte_n = resp[idx];
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                drop_n = i_RX_DV;
                if (i_TX_Done) begin
                    idx_n = {1'b0, idx} == len - 3'd1 ? 2'd0 : idx + 2'd1;
                    state_n = {1'b0, idx} == len - 3'd1 ? IDLE : SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
            sel <= 2'd0;
            timer <= '0;
            resp <= '0;
            len <= 3'd0;
            idx <= 2'd0;
            led <= 3'b111;
            o_TX_DV <= 1'b0;
            o_TX_Byte <= 8'h00;
            o_Cmd_Err <= 1'b0;
            o_Drop <= 1'b0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            timer <= timer_n;
            resp <= resp_n;
            len <= len_n;
            idx <= idx_n;
            led <= led_n;
            o_TX_DV <= tx_dv_n;
            o_TX_Byte <= tx_byte_n;
            o_Cmd_Err <= err_n;
            o_Drop <= drop_n;
        end
    end
    assign o_LED_R = led[2];
    assign o_LED_G = led[1];
    assign o_LED_B = led[0];
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: table-driven command vectors plus hand sequences for timing, timeout, drop, backpressure and reset
module tb_uart_cmd_ctrl;
    logic clk, rst_n, rx_dv, tx_dv, tx_done, model_active, hold_active, chk_hold;
    logic [7:0] rx_byte, tx_byte;
    logic led_r, led_g, led_b, cmd_err, drop;
    wire tx_active = model_active | hold_active;
    int total = 0, bad = 0, err_cnt = 0, drop_cnt = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int nb;
        logic [2:0] led;
        int nresp;
        logic [31:0] resp;
        int err;
    } vec_t;
    vec_t vecs[12];

    uart_cmd_ctrl #(.TIMEOUT_CLKS(16)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
        .o_LED_R(led_r), .o_LED_G(led_g), .o_LED_B(led_b), .o_Cmd_Err(cmd_err), .o_Drop(drop)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // UART_TX stand-in: 3 busy cycles per byte, then a one-cycle done pulse
    initial begin
        logic [7:0] cap;
        model_active = 0;
        tx_done = 0;
        forever begin
            @(posedge clk); #1;
            if (tx_dv) begin
                chk("tx_dv_while_active", {31'd0, hold_active}, 32'd0);
                cap = tx_byte;
                q.push_back(cap);
                model_active = 1;
                repeat (3) begin
                    @(posedge clk); #1;
                    if (chk_hold) chk("tx_byte_held", {24'd0, tx_byte}, {24'd0, cap});
                end
                tx_done = 1;
                model_active = 0;
                @(posedge clk); #1;
                tx_done = 0;
            end
        end
    end

    initial begin
        logic prev = 0;
        forever begin
            @(negedge clk);
            if (tx_dv) chk("tx_dv_back_to_back", {31'd0, prev}, 32'd0);
            prev = tx_dv;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (cmd_err) err_cnt++;
        if (drop) drop_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv = 1;
        @(posedge clk); #1;
        rx_dv = 0;
        rx_byte = 0;
    endtask

    task automatic wait_quiet(input int n);
        int c = 0, quiet = 0;
        while (c < 600 && !(q.size() >= n && quiet >= 8)) begin
            @(posedge clk); #1;
            quiet = (model_active || tx_dv || tx_done) ? 0 : quiet + 1;
            c++;
        end
        if (c >= 600) chk("wait_quiet_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_resp(input string name, input int n, input logic [31:0] r);
        logic [31:0] rr = r;
        chk({name, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < q.size()) chk({name, "_byte"}, {24'd0, q[i]}, {24'd0, rr[8*i +: 8]});
    endtask

    task automatic run_vec(input vec_t v);
        q.delete();
        err_cnt = 0;
        drop_cnt = 0;
        send_byte(v.b0);
        if (v.nb == 2) send_byte(v.b1);
        wait_quiet(v.nresp);
        chk("leds", {29'd0, led_r, led_g, led_b}, {29'd0, v.led});
        check_resp("resp", v.nresp, v.resp);
        chk("cmd_err_pulses", err_cnt, v.err);
        chk("drop_pulses", drop_cnt, 0);
    endtask

    initial begin
        vec_t v;
        int at;
        vecs[0]  = '{8'h47, 8'h31, 2, 3'b101, 3, 32'h000A4B4F, 0};
        vecs[1]  = '{8'h52, 8'h31, 2, 3'b001, 3, 32'h000A4B4F, 0};
        vecs[2]  = '{8'h42, 8'h31, 2, 3'b000, 3, 32'h000A4B4F, 0};
        vecs[3]  = '{8'h47, 8'h30, 2, 3'b010, 3, 32'h000A4B4F, 0};
        vecs[4]  = '{8'h3F, 8'h00, 1, 3'b010, 4, 32'h0A313031, 0};
        vecs[5]  = '{8'h58, 8'h00, 1, 3'b010, 3, 32'h000A3F45, 1};
        vecs[6]  = '{8'h52, 8'h37, 2, 3'b010, 3, 32'h000A3F45, 1};
        vecs[7]  = '{8'h42, 8'h30, 2, 3'b011, 3, 32'h000A4B4F, 0};
        vecs[8]  = '{8'h0D, 8'h00, 1, 3'b011, 0, 32'h00000000, 0};
        vecs[9]  = '{8'h0A, 8'h00, 1, 3'b011, 0, 32'h00000000, 0};
        vecs[10] = '{8'h3F, 8'h00, 1, 3'b011, 4, 32'h0A303031, 0};
        vecs[11] = '{8'h72, 8'h00, 1, 3'b011, 3, 32'h000A3F45, 1};
        rst_n = 1; rx_dv = 0; rx_byte = 0; hold_active = 0; chk_hold = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_leds", {29'd0, led_r, led_g, led_b}, 32'd7);
        chk("rst_tx", {23'd0, tx_dv, tx_byte}, 32'd0);
        chk("rst_pulses", {30'd0, cmd_err, drop}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // argument at edge N: LED updated right after N, first o_TX_DV one edge later
        q.delete();
        send_byte(8'h47);
        send_byte(8'h31);
        chk("arg_led_n1", {29'd0, led_r, led_g, led_b}, 32'd1);
        chk("arg_txdv_n1", {31'd0, tx_dv}, 32'd0);
        @(posedge clk); #1;
        chk("arg_txdv_n2", {31'd0, tx_dv}, 32'd1);
        wait_quiet(3);
        check_resp("arg_resp", 3, 32'h000A4B4F);

        // letter then silence: error after ~16 clocks, no response
        q.delete();
        err_cnt = 0;
        send_byte(8'h42);
        at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (cmd_err && at == 0) at = i;
        end
        total++;
        if (at < 15 || at > 17) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want 15..17", at);
        end
        chk("timeout_err_pulses", err_cnt, 1);
        chk("timeout_no_tx", q.size(), 0);
        chk("timeout_leds", {29'd0, led_r, led_g, led_b}, 32'd1);
        v = '{8'h42, 8'h31, 2, 3'b000, 3, 32'h000A4B4F, 0};
        run_vec(v);

        // byte arriving mid-response is dropped
        q.delete();
        err_cnt = 0;
        drop_cnt = 0;
        send_byte(8'h47);
        send_byte(8'h30);
        at = 0;
        while (!tx_dv && at < 20) begin
            @(posedge clk); #1;
            at++;
        end
        chk("drop_first_dv", {31'd0, tx_dv}, 32'd1);
        send_byte(8'h52);
        wait_quiet(3);
        chk("drop_pulses_seen", drop_cnt, 1);
        chk("drop_err", err_cnt, 0);
        chk("drop_leds", {29'd0, led_r, led_g, led_b}, 32'd2);
        check_resp("drop_resp", 3, 32'h000A4B4F);

        // UART_TX busy: response withheld until it frees up
        q.delete();
        hold_active = 1;
        send_byte(8'h42);
        send_byte(8'h30);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_no_tx", q.size(), 0);
        hold_active = 0;
        wait_quiet(3);
        chk("hold_leds", {29'd0, led_r, led_g, led_b}, 32'd3);
        check_resp("hold_resp", 3, 32'h000A4B4F);

        // async reset in the middle of a response
        q.delete();
        send_byte(8'h52);
        send_byte(8'h31);
        at = 0;
        while (!tx_dv && at < 20) begin
            @(posedge clk); #1;
            at++;
        end
        chk_hold = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("midrst_leds", {29'd0, led_r, led_g, led_b}, 32'd7);
        chk("midrst_tx", {23'd0, tx_dv, tx_byte}, 32'd0);
        chk("midrst_pulses", {30'd0, cmd_err, drop}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        at = 0;
        while ((model_active || tx_done) && at < 20) begin
            @(posedge clk); #1;
            at++;
        end
        chk_hold = 1;
        v = '{8'h3F, 8'h00, 1, 3'b111, 4, 32'h0A303030, 0};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-level command controller between the UART receiver and UART transmitter in the LED/UART top level. Parses short ASCII commands arriving on the RX data-valid/byte interface, sets the R/G/B LED states, and sequences a multi-byte ASCII response through the TX handshake one byte at a time. Replaces ad-hoc RX-to-LED logic with a single clocked FSM that also handles malformed input and inter-byte timeout.

## Interface

- TIMEOUT_CLKS, default 2500000: clocks allowed between command letter and argument (100 ms at 25 MHz); minimum 2.

- i_Clock  in  1  system clock (PLL 25 MHz domain, same as UART_RX/UART_TX)
- i_Rst_L  in  1  reset, asynchronous, active-low
- i_RX_DV  in  1  one-cycle pulse from UART_RX, byte valid
- i_RX_Byte  in  8  received byte, valid while i_RX_DV=1
- o_TX_DV  out  1  one-cycle pulse to UART_TX, start byte
- o_TX_Byte  out  8  byte to send, held stable from o_TX_DV until i_TX_Done
- i_TX_Active  in  1  UART_TX busy
- i_TX_Done  in  1  one-cycle pulse from UART_TX, stop bit complete
- o_LED_R, o_LED_G, o_LED_B  out  1 each  LED drive, active-low (0 = lit)
- o_Cmd_Err  out  1  one-cycle pulse: invalid command or timeout
- o_Drop  out  1  one-cycle pulse: RX byte discarded while responding

## Operation

- Commands (ASCII): letter 'R' 0x52, 'G' 0x47, 'B' 0x42 followed by '0' 0x30 (off) or '1' 0x31 (on); single byte '?' 0x3F (query).
- Bytes 0x0D and 0x0A in IDLE: ignored, no response, no error.
- States: IDLE, GET_ARG, SEND, WAIT_DONE.
- IDLE: on i_RX_DV: letter -> latch LED select, clear timer, GET_ARG. '?' -> load query response, SEND. CR/LF -> stay. Any other byte -> o_Cmd_Err, load error response, SEND.
- GET_ARG: timer increments each cycle. i_RX_DV with '0'/'1' -> update selected LED state, load "OK\n" (0x4F 0x4B 0x0A), SEND. i_RX_DV with other byte -> o_Cmd_Err, load "E?\n" (0x45 0x3F 0x0A), SEND. Timer reaches TIMEOUT_CLKS-1 without byte -> o_Cmd_Err, IDLE, no response, LEDs unchanged.
- Query response: 4 bytes: R, G, B state as '1' (lit) or '0', then 0x0A; states snapshotted in the cycle '?' is accepted.
- SEND: when i_TX_Active=0, pulse o_TX_DV with o_TX_Byte = response[idx], go WAIT_DONE. If i_TX_Active=1, hold.
- WAIT_DONE: on i_TX_Done, idx+1; if last byte sent -> IDLE, else SEND.
- Response buffer: 4 x 8 bits plus 3-bit length; idx 2 bits.
- i_RX_DV in SEND/WAIT_DONE: byte discarded, o_Drop pulse, state unaffected.
- Timer width: clog2(TIMEOUT_CLKS+1); saturates, never wraps.

## Timing

- Reset values: LED states off (o_LED_R/G/B = 1), o_TX_DV=0, o_TX_Byte=0x00, o_Cmd_Err=0, o_Drop=0, state IDLE, idx 0, timer 0.
- All outputs registered.
- i_RX_DV with argument at cycle N: LED output changes at N+1; first o_TX_DV at N+2 if i_TX_Active=0.
- i_RX_DV with invalid byte at N: o_Cmd_Err high at N+1 only.
- Between bytes: i_TX_Done at cycle M -> next o_TX_DV at M+2 (SEND at M+1, pulse registered).
- o_TX_DV never high for two consecutive cycles; never asserted while i_TX_Active=1.
- Simultaneous i_RX_DV and timeout expiry in GET_ARG: byte wins, treated as argument.
- Asynchronous reset mid-response: immediate return to reset values; remaining response bytes dropped; byte already in UART_TX completes independently.
- Timeout: letter at cycle N, no further byte -> o_Cmd_Err at N+TIMEOUT_CLKS (±1), state IDLE.

## Test plan

- Reset, send 'G','1' -> o_LED_G falls to 0 one cycle after '1'; TX bytes 0x4F,0x4B,0x0A in order, each o_TX_DV after previous i_TX_Done.
- Send 'R','1','B','1' back-to-back after each response, then '?' -> TX 0x31,0x30,0x31,0x0A; o_LED_R=0, o_LED_G=1, o_LED_B=0.
- Send 'X' -> o_Cmd_Err one pulse; TX 0x45,0x3F,0x0A; LEDs unchanged. Send 'R','7' -> same error response, o_LED_R unchanged.
- TIMEOUT_CLKS=16: send 'B', no further byte -> o_Cmd_Err ~16 cycles later, no o_TX_DV, next 'B','1' works normally.
- Send 'G','1' and inject 'R' during WAIT_DONE -> o_Drop pulse, response still "OK\n" complete, o_LED_R unchanged; hold i_TX_Active=1 in SEND -> o_TX_DV withheld until it drops.
- Assert i_Rst_L=0 mid-response after 'R','1' -> all outputs at reset values asynchronously, o_LED_R=1; after release, '?' -> 0x30,0x30,0x30,0x0A.
